// File: rtl/mosbius_pkg.sv
// Shared types and CRC helper for the MOSbius configuration-chain loader.
package mosbius_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CRC_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LATCH,
    ST_CLR,
    ST_FINISH
  } cfg_state_t;

  localparam logic [CRC_W-1:0] MOSBIUS_CRC_POLY = 8'h07;

  // One MSB-first CRC-8 update with a single message bit.
  function automatic logic [CRC_W-1:0] crc8_step(input logic [CRC_W-1:0] crc, input logic b);
    logic fb;
    fb = crc[CRC_W-1] ^ b;
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? MOSBIUS_CRC_POLY : '0);
  endfunction

endpackage

// File: rtl/mosbius_cfg_loader_if.sv
// Byte-stream and switch-matrix pin bundle for mosbius_cfg_loader.
// rb_crc exists only when MOSBIUS_READBACK_EN is defined.
interface mosbius_cfg_loader_if;
  import mosbius_pkg::*;

  logic              start;
  logic              clear;
  logic [BYTE_W-1:0] byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              busy;
  logic              done;
  logic              sr_clk;
  logic              sr_dat;
  logic              sr_en;
  logic              sr_rst_n;
  logic              sr_dout;
`ifdef MOSBIUS_READBACK_EN
  logic [CRC_W-1:0]  rb_crc;

  modport master (
    output start, clear, byte_in, byte_valid, sr_dout,
    input  byte_ready, busy, done, sr_clk, sr_dat, sr_en, sr_rst_n, rb_crc
  );
  modport slave (
    input  start, clear, byte_in, byte_valid, sr_dout,
    output byte_ready, busy, done, sr_clk, sr_dat, sr_en, sr_rst_n, rb_crc
  );
`else
  modport master (
    output start, clear, byte_in, byte_valid, sr_dout,
    input  byte_ready, busy, done, sr_clk, sr_dat, sr_en, sr_rst_n
  );
  modport slave (
    input  start, clear, byte_in, byte_valid, sr_dout,
    output byte_ready, busy, done, sr_clk, sr_dat, sr_en, sr_rst_n
  );
`endif
endinterface

// File: rtl/mosbius_clkdiv_tick.sv
// Phase timer: tick_c is high in the LEN-th cycle after the last restart.
module mosbius_clkdiv_tick #(
  parameter int unsigned LEN = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick_c
);
  localparam int unsigned CNT_W = $clog2(LEN + 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick_c = (cnt_q == CNT_W'(LEN - 1));

  // Saturates at the tick so a phase that is not left keeps reporting its end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cnt_q <= '0;
    else if (restart)  cnt_q <= '0;
    else if (!tick_c)  cnt_q <= cnt_q + CNT_W'(1);
  end
endmodule

// File: rtl/mosbius_cfg_loader.sv
// Serializes a configuration byte stream MSB-first into the MOSbius switch chain,
// then pulses the latch enable. Optional CRC readback of sr_dout: MOSBIUS_READBACK_EN.
module mosbius_cfg_loader
  import mosbius_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 100,
  parameter int unsigned HALF_PER  = 2,
  parameter int unsigned EN_CYC    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mosbius_cfg_loader_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int unsigned SUB_W = $clog2(BYTE_W);

  cfg_state_t        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [SUB_W-1:0]  sub_q, sub_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              sr_dat_d;
  logic              half_tick_c, en_tick_c, restart_c;

  logic ready_q, busy_q, done_q, sr_clk_q, sr_dat_q, sr_en_q, sr_rst_n_q;

  assign restart_c = (state_d != state_q);

  mosbius_clkdiv_tick #(.LEN(HALF_PER)) u_half_tick (
    .clk(clk), .rst_n(rst_n), .restart(restart_c), .tick_c(half_tick_c)
  );
  mosbius_clkdiv_tick #(.LEN(EN_CYC)) u_en_tick (
    .clk(clk), .rst_n(rst_n), .restart(restart_c), .tick_c(en_tick_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sub_d     = sub_q;
    shift_d   = shift_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.clear) begin
          state_d = ST_CLR;
        end else if (bus.start) begin
          state_d   = ST_FETCH;
          bit_cnt_d = '0;
        end
      end
      ST_FETCH: begin
        if (bus.byte_valid && bus.byte_ready) begin
          shift_d = bus.byte_in;
          sub_d   = '0;
          state_d = ST_SHIFT_LO;
        end
      end
      ST_SHIFT_LO: if (half_tick_c) state_d = ST_SHIFT_HI;
      ST_SHIFT_HI: begin
        if (half_tick_c) begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          sub_d     = sub_q + SUB_W'(1);
          shift_d   = {shift_q[BYTE_W-2:0], 1'b0};
          if (bit_cnt_d == CNT_W'(CHAIN_LEN))     state_d = ST_LATCH;
          else if (sub_q == SUB_W'(BYTE_W - 1))   state_d = ST_FETCH;
          else                                    state_d = ST_SHIFT_LO;
        end
      end
      ST_LATCH:  if (en_tick_c) state_d = ST_FINISH;
      ST_CLR:    if (en_tick_c) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Data is presented for the whole low phase and held everywhere else.
  assign sr_dat_d = (state_d == ST_SHIFT_LO) ? shift_d[BYTE_W-1] : sr_dat_q;

  // Outputs are registered from the next state so they line up with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q  <= '0;
      sub_q      <= '0;
      shift_q    <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sr_clk_q   <= 1'b0;
      sr_dat_q   <= 1'b0;
      sr_en_q    <= 1'b0;
      sr_rst_n_q <= 1'b1;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      sub_q      <= sub_d;
      shift_q    <= shift_d;
      ready_q    <= (state_d == ST_FETCH);
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= (state_d == ST_FINISH);
      sr_clk_q   <= (state_d == ST_SHIFT_HI);
      sr_dat_q   <= sr_dat_d;
      sr_en_q    <= (state_d == ST_LATCH);
      sr_rst_n_q <= (state_d != ST_CLR);
    end
  end

  assign bus.byte_ready = ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.sr_clk     = sr_clk_q;
  assign bus.sr_dat     = sr_dat_q;
  assign bus.sr_en      = sr_en_q;
  assign bus.sr_rst_n   = sr_rst_n_q;

`ifdef MOSBIUS_READBACK_EN
  logic [CRC_W-1:0] crc_q;

  // Chain output is sampled on the edge that raises sr_clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      crc_q <= '0;
    else if (state_q == ST_IDLE && bus.start && !bus.clear)
      crc_q <= '0;
    else if (state_q == ST_SHIFT_LO && state_d == ST_SHIFT_HI)
      crc_q <= crc8_step(crc_q, bus.sr_dout);
  end

  assign bus.rb_crc = crc_q;
`endif
endmodule

// File: tb/tb_mosbius_cfg_loader.sv
// Bench for mosbius_cfg_loader: directed and random loads against a stream-level model.
// Readback checks compile in with MOSBIUS_READBACK_EN.
module tb_mosbius_cfg_loader;
  localparam int unsigned CL = 12;
  localparam int unsigned HP = 1;
  localparam int unsigned EC = 4;
  localparam int NBYTES = (CL + 7) / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mosbius_cfg_loader_if bus ();

  mosbius_cfg_loader #(.CHAIN_LEN(CL), .HALF_PER(HP), .EN_CYC(EC)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bits_n = 0, en_cyc = 0, en_rises = 0, done_cnt = 0, rstlo_cnt = 0, ready_cnt = 0, hs_cnt = 0;
  logic [CL-1:0] bits_w = '0;
  logic prev_clk = 1'b0, prev_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

`ifdef MOSBIUS_READBACK_EN
  logic [CL-1:0] chain;
  logic preload = 1'b0;
  always @(posedge bus.sr_clk or negedge bus.sr_rst_n or posedge preload) begin
    if (!bus.sr_rst_n)  chain <= '0;
    else if (preload)   chain <= {CL{1'b1}};
    else                chain <= {chain[CL-2:0], bus.sr_dat};
  end
  assign bus.sr_dout = chain[CL-1];

  // Remainder of msg * x^8 modulo x^8+x^2+x+1.
  function automatic logic [7:0] crc_ref(input logic [CL-1:0] msg);
    logic [CL+7:0] r;
    r = {msg, 8'h00};
    for (int i = CL + 7; i >= 8; i--)
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    return r[7:0];
  endfunction
`else
  assign bus.sr_dout = 1'b0;
`endif

  // Pin monitor: observed serial bits and pulse statistics.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.sr_clk && !prev_clk) begin
        bits_w = {bits_w[CL-2:0], bus.sr_dat};
        bits_n++;
      end
      if (bus.sr_en) begin
        en_cyc++;
        check("sr_clk_low_in_latch", 32'(bus.sr_clk), 32'd0);
      end
      if (bus.sr_en && !prev_en) en_rises++;
      if (bus.byte_ready) begin
        ready_cnt++;
        check("sr_clk_low_in_fetch", 32'(bus.sr_clk), 32'd0);
      end
      if (bus.byte_ready && bus.byte_valid) hs_cnt++;
      if (bus.done) done_cnt++;
      if (!bus.sr_rst_n) rstlo_cnt++;
    end
    prev_clk = bus.sr_clk;
    prev_en  = bus.sr_en;
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_sr_clk"},     32'(bus.sr_clk),     32'd0);
    check({tag, "_sr_dat"},     32'(bus.sr_dat),     32'd0);
    check({tag, "_sr_en"},      32'(bus.sr_en),      32'd0);
    check({tag, "_sr_rst_n"},   32'(bus.sr_rst_n),   32'd1);
    check({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'd0);
    check({tag, "_busy"},       32'(bus.busy),       32'd0);
    check({tag, "_done"},       32'(bus.done),       32'd0);
`ifdef MOSBIUS_READBACK_EN
    check({tag, "_rb_crc"},     32'(bus.rb_crc),     32'd0);
`endif
  endtask

  // Drives one load; optional stall before byte 2, spurious start, or reset after N bits.
  task automatic run_load(input logic [7:0] b0, input logic [7:0] b1, input int stall,
                          input int spur_k, input int abort_bits, output int lat);
    int c0, idx, waitc, nb0;
    bit acc;
    logic [7:0] fb [2];
    fb[0] = b0; fb[1] = b1;
    idx = 0; waitc = 0; lat = -1; nb0 = bits_n;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.byte_in = b0; bus.byte_valid = 1'b1; c0 = cyc;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (bus.done) begin
        lat = cyc - c0 + 1;
        break;
      end
      if (abort_bits > 0 && bits_n - nb0 >= abort_bits) begin
        rst_n = 1'b0; #1;
        check_reset_values("abort");
        @(posedge clk); #1;
        rst_n = 1'b1;
        break;
      end
      acc = bus.byte_ready && bus.byte_valid;
      if (bus.byte_ready && !bus.byte_valid) waitc++;
      @(posedge clk); #1;
      bus.start = (k + 1 == spur_k);
`ifdef MOSBIUS_READBACK_EN
      if (k == 0) check("rb_crc_cleared_at_start", 32'(bus.rb_crc), 32'd0);
`endif
      if (acc) begin
        idx++;
        if (idx < NBYTES) bus.byte_in = fb[idx];
        bus.byte_valid = !(idx == 1 && stall > 0);
      end else if (idx == 1 && !bus.byte_valid && waitc >= stall) begin
        bus.byte_valid = 1'b1;
      end
    end
    bus.start = 1'b0;
    bus.byte_valid = 1'b0;
  endtask

  task automatic full_load(input logic [7:0] b0, input logic [7:0] b1, input int stall, input int spur_k);
    int lat, e0, r0, d0, h0, n0;
    logic [15:0] s;
    logic [CL-1:0] exp_bits;
`ifdef MOSBIUS_READBACK_EN
    logic [CL-1:0] snap;
    snap = chain;
`endif
    s = {b0, b1};
    exp_bits = s[15 -: CL];
    e0 = en_cyc; r0 = en_rises; d0 = done_cnt; h0 = hs_cnt; n0 = bits_n;
    run_load(b0, b1, stall, spur_k, 0, lat);
    repeat (6) @(negedge clk);
    #1;
    check("serial_bits",  32'(bits_w), 32'(exp_bits));
    check("bit_count",    32'(bits_n - n0), 32'(CL));
    check("en_width",     32'(en_cyc - e0), 32'(EC));
    check("en_rises",     32'(en_rises - r0), 32'd1);
    check("handshakes",   32'(hs_cnt - h0), 32'(NBYTES));
    check("done_once",    32'(done_cnt - d0), 32'd1);
    check("latency",      32'(lat), 32'(1 + CL * 2 * HP + NBYTES + EC + 1 + stall));
    check("idle_after",   32'(bus.busy), 32'd0);
`ifdef MOSBIUS_READBACK_EN
    check("rb_crc",       32'(bus.rb_crc), 32'(crc_ref(snap)));
    check("chain_image",  32'(chain), 32'(exp_bits));
`endif
  endtask

  initial begin
    int lat, r0, rd0, d0, er0;
    bus.start = 1'b0; bus.clear = 1'b0; bus.byte_in = '0; bus.byte_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;

`ifdef MOSBIUS_READBACK_EN
    preload = 1'b1; #1; preload = 1'b0;
`endif
    full_load(8'hA5, 8'hF0, 0, 0);
    full_load(8'($urandom), 8'($urandom), 5, 0);

    // Clear and start together: clear wins.
    r0 = rstlo_cnt; rd0 = ready_cnt; d0 = done_cnt;
`ifdef MOSBIUS_READBACK_EN
    er0 = 32'(bus.rb_crc);
`else
    er0 = 0;
`endif
    @(posedge clk); #1;
    bus.clear = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0; bus.start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (bus.done) break;
    end
    repeat (5) @(negedge clk);
    #1;
    check("clear_rst_width", 32'(rstlo_cnt - r0), 32'(EC));
    check("clear_no_ready",  32'(ready_cnt - rd0), 32'd0);
    check("clear_done_once", 32'(done_cnt - d0), 32'd1);
`ifdef MOSBIUS_READBACK_EN
    check("clear_keeps_crc", 32'(bus.rb_crc), 32'(er0));
`else
    check("clear_idle",      32'(bus.busy), 32'(er0));
`endif

    // Reset after bit 6 of a load.
    er0 = en_rises; d0 = done_cnt;
    run_load(8'($urandom), 8'($urandom), 0, 0, 6, lat);
    repeat (20) @(negedge clk);
    #1;
    check("abort_no_en",   32'(en_rises - er0), 32'd0);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_idle",    32'(bus.busy), 32'd0);
    full_load(8'($urandom), 8'($urandom), 0, 0);

    // Start while busy is ignored.
    full_load(8'($urandom), 8'($urandom), 0, 10);

    for (int i = 0; i < 3; i++)
      full_load(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
